// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is resolved per stage,
// behind an input operand register, with a single stall enable shared by every register.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             GG,
    output logic             PG,
    output logic             OVF
);
    localparam int unsigned NSTAGE = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end

    typedef struct packed {
        logic [GROUP-1:0] s;
        logic             co;
        logic             g;
        logic             p;
        logic             cmsb;
    } grp_t;

    // Every carry inside the group is formed directly from span generate/propagate terms.
    function automatic grp_t grp_cla(input logic [GROUP-1:0] a, input logic [GROUP-1:0] b,
                                     input logic ci);
        grp_t             r;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             gs;
        logic             ps;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        gs   = 1'b0;
        ps   = 1'b1;
        for (int i = 0; i < int'(GROUP); i++) begin
            gs = g[i];
            ps = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gs = gs | (ps & g[j]);
                ps = ps & p[j];
            end
            c[i+1] = gs | (ps & ci);
        end
        r.s    = p ^ c[GROUP-1:0];
        r.co   = c[GROUP];
        r.g    = gs;
        r.p    = ps;
        r.cmsb = c[GROUP-1];
        return r;
    endfunction

    logic             adv;
    logic             iv_q;
    logic [WIDTH-1:0] ia_q;
    logic [WIDTH-1:0] ib_q;
    logic             icin_q;
    logic             isub_q;

    logic             vld_q [NSTAGE];
    logic             vld_d [NSTAGE];
    logic [WIDTH-1:0] sum_q [NSTAGE];
    logic [WIDTH-1:0] sum_d [NSTAGE];
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] a_d   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic [WIDTH-1:0] b_d   [NSTAGE];
    logic             c_q   [NSTAGE];
    logic             c_d   [NSTAGE];
    logic             g_q   [NSTAGE];
    logic             g_d   [NSTAGE];
    logic             p_q   [NSTAGE];
    logic             p_d   [NSTAGE];
    logic             ovf_q [NSTAGE];
    logic             ovf_d [NSTAGE];

    assign out_valid = vld_q[NSTAGE-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign S         = sum_q[NSTAGE-1];
    assign Cout      = c_q[NSTAGE-1];
    assign GG        = g_q[NSTAGE-1];
    assign PG        = p_q[NSTAGE-1];
    assign OVF       = ovf_q[NSTAGE-1];

    always_comb begin
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic             sv;
        logic             sc;
        logic             sg;
        logic             sp;
        int               kp;
        grp_t             r;
        sa = '0;
        sb = '0;
        ss = '0;
        sv = 1'b0;
        sc = 1'b0;
        sg = 1'b0;
        sp = 1'b1;
        kp = 0;
        r  = '0;
        for (int k = 0; k < int'(NSTAGE); k++) begin
            kp = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // SUB is consumed here; later stages only see the already inverted operand.
                sa = ia_q;
                sb = isub_q ? ~ib_q : ib_q;
                ss = '0;
                sv = iv_q;
                sc = isub_q | icin_q;
                sg = 1'b0;
                sp = 1'b1;
            end else begin
                sa = a_q[kp];
                sb = b_q[kp];
                ss = sum_q[kp];
                sv = vld_q[kp];
                sc = c_q[kp];
                sg = g_q[kp];
                sp = p_q[kp];
            end
            r = grp_cla(sa[k*GROUP +: GROUP], sb[k*GROUP +: GROUP], sc);
            vld_d[k] = sv;
            sum_d[k] = ss;
            sum_d[k][k*GROUP +: GROUP] = r.s;
            a_d[k]   = sa;
            b_d[k]   = sb;
            c_d[k]   = r.co;
            g_d[k]   = r.g | (r.p & sg);
            p_d[k]   = r.p & sp;
            ovf_d[k] = r.cmsb ^ r.co;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q   <= 1'b0;
            ia_q   <= '0;
            ib_q   <= '0;
            icin_q <= 1'b0;
            isub_q <= 1'b0;
            for (int k = 0; k < int'(NSTAGE); k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                g_q[k]   <= 1'b0;
                p_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
            end
        end else if (adv) begin
            // Operands of an empty slot are zeroed so bubbles carry known data.
            iv_q   <= in_valid;
            ia_q   <= in_valid ? A : '0;
            ib_q   <= in_valid ? B : '0;
            icin_q <= in_valid & Cin;
            isub_q <= in_valid & SUB;
            for (int k = 0; k < int'(NSTAGE); k++) begin
                vld_q[k] <= vld_d[k];
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                c_q[k]   <= c_d[k];
                g_q[k]   <= g_d[k];
                p_q[k]   <= p_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: scoreboard on a 16/4 instance plus a corner-vector
// sweep over three further width/group configurations.
module tb_cla_pipe_addsub;
    localparam int W   = 16;
    localparam int G   = 4;
    localparam int NST = W / G;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        gg;
        logic        pg;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          cout;
    logic          gg;
    logic          pg;
    logic          ovf;

    logic          sw_valid;
    logic          sw_ready;
    logic          sw_cin;
    logic          sw_sub;
    logic [7:0]    a8, b8, s8;
    logic [31:0]   a32, b32, s32;
    logic [63:0]   a64, b64, s64;
    logic          rdy8, rdy32, rdy64;
    logic          ov8, ov32, ov64;
    logic          co8, co32, co64;
    logic          gg8, gg32, gg64;
    logic          pg8, pg32, pg64;
    logic          of8, of32, of64;

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    res_t exp_q[$];
    res_t got_m;
    res_t exp_m;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .Cin(cin), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready), .S(s),
        .Cout(cout), .GG(gg), .PG(pg), .OVF(ovf)
    );

    cla_pipe_addsub #(.WIDTH(8), .GROUP(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8), .A(a8), .B(b8),
        .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov8), .out_ready(sw_ready), .S(s8),
        .Cout(co8), .GG(gg8), .PG(pg8), .OVF(of8)
    );

    cla_pipe_addsub #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32), .A(a32), .B(b32),
        .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov32), .out_ready(sw_ready), .S(s32),
        .Cout(co32), .GG(gg32), .PG(pg32), .OVF(of32)
    );

    cla_pipe_addsub #(.WIDTH(64), .GROUP(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64), .A(a64), .B(b64),
        .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov64), .out_ready(sw_ready), .S(s64),
        .Cout(co64), .GG(gg64), .PG(pg64), .OVF(of64)
    );

    // Reference: plain wide arithmetic, GG is the carry out with no carry in, PG all bits XOR.
    function automatic res_t model(int w, logic [63:0] ia, logic [63:0] ib, logic ic, logic isb);
        logic [63:0] m;
        logic [63:0] am;
        logic [63:0] bb;
        logic [64:0] full;
        logic [64:0] gen;
        res_t        r;
        m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = ia & m;
        bb   = (isb ? ~ib : ib) & m;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, isb | ic};
        gen  = {1'b0, am} + {1'b0, bb};
        r.s    = full[63:0] & m;
        r.cout = full[w];
        r.gg   = gen[w];
        r.pg   = &((am ^ bb) | ~m);
        r.ovf  = (am[w-1] == bb[w-1]) && (r.s[w-1] != am[w-1]);
        return r;
    endfunction

    function automatic op_t vec(int p, int w);
        logic [63:0] m;
        logic [63:0] msb;
        logic [63:0] alt;
        op_t         o;
        int          bnd;
        m   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb = 64'd1 << (w - 1);
        alt = 64'h5555_5555_5555_5555;
        o   = '0;
        case (p)
            0:  o = '{a: 64'd0,     b: 64'd0,     cin: 1'b0, sub: 1'b0};
            1:  o = '{a: m,         b: 64'd0,     cin: 1'b0, sub: 1'b0};
            2:  o = '{a: m,         b: 64'd1,     cin: 1'b0, sub: 1'b0};
            3:  o = '{a: m,         b: 64'd0,     cin: 1'b1, sub: 1'b0};
            4:  o = '{a: msb,       b: msb,       cin: 1'b0, sub: 1'b0};
            5:  o = '{a: msb - 1,   b: 64'd1,     cin: 1'b0, sub: 1'b0};
            6:  o = '{a: 64'd0,     b: 64'd1,     cin: 1'b1, sub: 1'b1};
            7:  o = '{a: msb,       b: 64'd1,     cin: 1'b0, sub: 1'b1};
            8:  o = '{a: m,         b: m,         cin: 1'b1, sub: 1'b0};
            9:  o = '{a: alt & m,   b: ~alt & m,  cin: 1'b1, sub: 1'b0};
            default: begin
                bnd = (p - 9) * (w / 4);
                o   = '{a: (64'd1 << bnd) - 64'd1, b: 64'd1, cin: 1'b0, sub: 1'b0};
            end
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                pops++;
                got_m = '{s: 64'(s), cout: cout, gg: gg, pg: pg, ovf: ovf};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_result: got S=%h Cout=%b with none expected", s, cout);
                end else begin
                    exp_m = exp_q.pop_front();
                    if (got_m !== exp_m) begin
                        bad++;
                        $display("FAIL result_order: got %h/%b%b%b%b want %h/%b%b%b%b",
                                 got_m.s, got_m.cout, got_m.gg, got_m.pg, got_m.ovf,
                                 exp_m.s, exp_m.cout, exp_m.gg, exp_m.pg, exp_m.ovf);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back(model(W, 64'(a), 64'(b), cin, sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b1; sw_cin = 1'b0; sw_sub = 1'b0;
        a8 = '0; b8 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if ({s, cout, gg, pg, ovf} !== '0) begin
            bad++; $display("FAIL reset_outputs: got S=%h flags=%b%b%b%b want 0", s, cout, gg, pg, ovf);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_wrap_latency();
        int lat;
        out_ready = 1'b1;
        a = 16'h0001; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== NST) begin
            bad++; $display("FAIL latency: got %0d cycles want %0d", lat, NST);
        end
        total++;
        if ({s, cout, gg, pg, ovf} !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL wrap_vector: got S=%h C/GG/PG/OVF=%b%b%b%b want 0000 1100",
                            s, cout, gg, pg, ovf);
        end
        tick();
    endtask

    task automatic test_overflow_sub();
        int n;
        out_ready = 1'b1;
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0005; b = 16'h0007; cin = 1'b0; sub = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if ({out_valid, s, cout, ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
            bad++; $display("FAIL signed_overflow: got v=%b S=%h C=%b OVF=%b want 1 8000 0 1",
                            out_valid, s, cout, ovf);
        end
        tick();
        total++;
        if ({out_valid, s, cout, ovf} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
            bad++; $display("FAIL subtract_borrow: got v=%b S=%h C=%b OVF=%b want 1 fffe 0 0",
                            out_valid, s, cout, ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int p0;
        int not_ready;
        p0 = pops;
        not_ready = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            if (in_ready !== 1'b1) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < NST + 2 && exp_q.size() != 0; i++) tick();
        total++;
        if (not_ready != 0) begin
            bad++; $display("FAIL stream_in_ready: got %0d stalled cycles want 0", not_ready);
        end
        total++;
        if (pops - p0 != 100 || exp_q.size() != 0) begin
            bad++; $display("FAIL stream_count: got %0d results (%0d left) want 100 (0 left)",
                            pops - p0, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int   p0;
        logic have;
        res_t snap;
        res_t now;
        p0 = pops;
        have = 1'b0;
        snap = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid === 1'b1) begin
                now = '{s: 64'(s), cout: cout, gg: gg, pg: pg, ovf: ovf};
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready, c);
                end
                if (have) begin
                    total++;
                    if (now !== snap) begin
                        bad++; $display("FAIL stall_hold: got S=%h want S=%h", now.s, snap.s);
                    end
                end
                snap = now;
                have = 1'b1;
            end
        end
        total++;
        if (have !== 1'b1) begin
            bad++; $display("FAIL stall_out_valid: got no result during stall want one");
        end
        out_ready = 1'b1;
        for (int i = 0; i < NST + 6 && exp_q.size() != 0; i++) tick();
        total++;
        if (pops - p0 != 4 || exp_q.size() != 0) begin
            bad++; $display("FAIL stall_drain: got %0d results (%0d left) want 4 (0 left)",
                            pops - p0, exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL flush_stale: got %0d stale results want 0", seen);
        end
    endtask

    task automatic test_param_sweep();
        op_t  o8, o32, o64;
        res_t e8, e32, e64;
        res_t g;
        logic [2:0] seen;
        for (int p = 0; p < 13; p++) begin
            o8  = vec(p, 8);
            o32 = vec(p, 32);
            o64 = vec(p, 64);
            a8  = o8.a[7:0];   b8  = o8.b[7:0];
            a32 = o32.a[31:0]; b32 = o32.b[31:0];
            a64 = o64.a;       b64 = o64.b;
            sw_cin = o8.cin; sw_sub = o8.sub; sw_valid = 1'b1;
            e8  = model(8,  o8.a,  o8.b,  o8.cin,  o8.sub);
            e32 = model(32, o32.a, o32.b, o32.cin, o32.sub);
            e64 = model(64, o64.a, o64.b, o64.cin, o64.sub);
            total++;
            if ({rdy8, rdy32, rdy64} !== 3'b111) begin
                bad++; $display("FAIL sweep_ready: got %b want 111", {rdy8, rdy32, rdy64});
            end
            tick();
            sw_valid = 1'b0;
            seen = '0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (ov8 === 1'b1) begin
                    seen[0] = 1'b1; total++;
                    g = '{s: 64'(s8), cout: co8, gg: gg8, pg: pg8, ovf: of8};
                    if (g !== e8) begin
                        bad++; $display("FAIL sweep8_vec%0d: got %h/%b%b%b%b want %h/%b%b%b%b", p,
                                        g.s, g.cout, g.gg, g.pg, g.ovf, e8.s, e8.cout, e8.gg, e8.pg, e8.ovf);
                    end
                end
                if (ov32 === 1'b1) begin
                    seen[1] = 1'b1; total++;
                    g = '{s: 64'(s32), cout: co32, gg: gg32, pg: pg32, ovf: of32};
                    if (g !== e32) begin
                        bad++; $display("FAIL sweep32_vec%0d: got %h/%b%b%b%b want %h/%b%b%b%b", p,
                                        g.s, g.cout, g.gg, g.pg, g.ovf, e32.s, e32.cout, e32.gg, e32.pg, e32.ovf);
                    end
                end
                if (ov64 === 1'b1) begin
                    seen[2] = 1'b1; total++;
                    g = '{s: s64, cout: co64, gg: gg64, pg: pg64, ovf: of64};
                    if (g !== e64) begin
                        bad++; $display("FAIL sweep64_vec%0d: got %h/%b%b%b%b want %h/%b%b%b%b", p,
                                        g.s, g.cout, g.gg, g.pg, g.ovf, e64.s, e64.cout, e64.gg, e64.pg, e64.ovf);
                    end
                end
            end
            total++;
            if (seen !== 3'b111) begin
                bad++; $display("FAIL sweep_timeout_vec%0d: got results from %b want 111", p, seen);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_latency();
        test_overflow_sub();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
